// File: rtl/bs_pkg.sv
// Shared types and constants for the bit-serial accumulator controller.
package bs_pkg;

  // Operand width and shift cycles per operation.
  localparam int WIDTH_DEF = 8;

  // Operation codes; 6 and 7 are reserved and run as a no-op.
  typedef enum logic [2:0] {
    NOP  = 3'd0,
    LOAD = 3'd1,
    ADD  = 3'd2,
    SUB  = 3'd3,
    CLR  = 3'd4,
    ROT  = 3'd5
  } op_e;

  // Accumulator serial-input source.
  typedef enum logic [1:0] {
    MEM  = 2'd0,
    SUM  = 2'd1,
    LOOP = 2'd2
  } src_e;

  // Ops that need the shift sequence; anything else goes straight to DONE.
  function automatic logic is_exec_op(input op_e op);
    logic r;
    case (op)
      LOAD, ADD, SUB, CLR, ROT: r = 1'b1;
      default:                  r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/bs_bit_counter.sv
// Bit index counter: clear beats enable, terminal count flags WIDTH-1.
module bs_bit_counter
  import bs_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  localparam int CW = $clog2(WIDTH)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_clear,
  input  logic          i_en,
  output logic [CW-1:0] o_cnt,
  output logic          o_tc
);

  logic [CW-1:0] cnt_q, cnt_d;

  // Next count: clear wins so the last shift never wraps into a new index.
  always_comb begin
    cnt_d = cnt_q;
    if (i_clear)   cnt_d = '0;
    else if (i_en) cnt_d = cnt_q + CW'(1);
  end

  // Count register with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign o_cnt = cnt_q;
  assign o_tc  = (cnt_q == CW'(WIDTH - 1));

endmodule

// File: rtl/bit_serial_controller.sv
// Sequencer for a bit-serial accumulator: accepts one op, drives WIDTH
// shift cycles (stallable), then pulses done for a single cycle.
module bit_serial_controller
  import bs_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  localparam int CW = $clog2(WIDTH)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_valid,
  input  op_e           i_op,
  input  logic          i_stall,
  output logic          o_ready,
  output logic          o_acc_shift,
  output logic          o_acc_write,
  output src_e          o_src_sel,
  output logic          o_carry_init,
  output logic          o_carry_val,
  output logic          o_invert_b,
  output logic [CW-1:0] o_bit_idx,
  output logic          o_busy,
  output logic          o_done
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]    state_q, state_d;
  op_e           op_q, op_d;
  logic          accept, shift_en, last_shift;
  logic [CW-1:0] cnt;
  logic          cnt_tc;

  assign accept     = (state_q == S_IDLE) && i_valid;
  assign shift_en   = (state_q == S_EXEC) && !i_stall;
  assign last_shift = shift_en && cnt_tc;

  bs_bit_counter #(.WIDTH(WIDTH)) u_cnt (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_clear (accept || last_shift),
    .i_en    (shift_en),
    .o_cnt   (cnt),
    .o_tc    (cnt_tc)
  );

  // Next-state and op latch; the op is captured only at accept.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (is_exec_op(i_op)) begin
            state_d = S_EXEC;
            op_d    = i_op;
          end else begin
            state_d = S_DONE;
            op_d    = NOP;
          end
        end
      end
      S_EXEC: if (last_shift) state_d = S_DONE;
      S_DONE: begin
        state_d = S_IDLE;
        op_d    = NOP;
      end
      default: begin
        state_d = S_IDLE;
        op_d    = NOP;
      end
    endcase
  end

  // State register; reset overrides any in-flight operation.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      op_q    <= NOP;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
    end
  end

  // Output decode; every output is forced to its idle value while in reset
  // so an aborted op shows nothing even in the reset cycle itself.
  always_comb begin
    o_ready      = i_rst || (state_q == S_IDLE);
    o_acc_shift  = 1'b0;
    o_acc_write  = 1'b0;
    o_src_sel    = MEM;
    o_carry_init = 1'b0;
    o_carry_val  = 1'b0;
    o_invert_b   = 1'b0;
    o_bit_idx    = '0;
    o_busy       = 1'b0;
    o_done       = 1'b0;
    if (!i_rst) begin
      o_busy = (state_q == S_EXEC) || (state_q == S_DONE);
      o_done = (state_q == S_DONE);
      if (state_q == S_EXEC) o_bit_idx = cnt;
      // Carry seed is the only output allowed to follow i_valid directly.
      if (accept && is_exec_op(i_op)) begin
        o_carry_init = 1'b1;
        o_carry_val  = (i_op == SUB);
      end
      if (shift_en) begin
        o_acc_shift = 1'b1;
        case (op_q)
          LOAD: begin
            o_acc_write = 1'b1;
            o_src_sel   = MEM;
          end
          ADD: begin
            o_acc_write = 1'b1;
            o_src_sel   = SUM;
          end
          SUB: begin
            o_acc_write = 1'b1;
            o_src_sel   = SUM;
            o_invert_b  = 1'b1;
          end
          ROT: begin
            o_acc_write = 1'b1;
            o_src_sel   = LOOP;
          end
          default: o_acc_write = 1'b0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_bit_serial_controller.sv
// Directed bench: every cycle the full output vector is compared against a
// hand-built expectation.
module tb_bit_serial_controller;
  import bs_pkg::*;

  logic       clk;
  logic       rst;
  logic       valid;
  op_e        op;
  logic       stall;
  logic       ready, shift, write, cinit, cval, inv, busy, done;
  src_e       src;
  logic [2:0] idx;
  logic [1:0] src_bits;
  logic [12:0] obs;

  int total = 0;
  int bad   = 0;

  bit_serial_controller #(.WIDTH(8)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_valid      (valid),
    .i_op         (op),
    .i_stall      (stall),
    .o_ready      (ready),
    .o_acc_shift  (shift),
    .o_acc_write  (write),
    .o_src_sel    (src),
    .o_carry_init (cinit),
    .o_carry_val  (cval),
    .o_invert_b   (inv),
    .o_bit_idx    (idx),
    .o_busy       (busy),
    .o_done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign src_bits = src;
  assign obs = {ready, shift, write, src_bits, cinit, cval, inv, idx, busy, done};

  // {ready, shift, write, src[1:0], cinit, cval, inv, idx[2:0], busy, done}
  function automatic logic [12:0] v(input bit rdy, input bit sh, input bit wr,
                                    input logic [1:0] s, input bit ci, input bit cv,
                                    input bit iv, input logic [2:0] ix,
                                    input bit bz, input bit dn);
    return {rdy, sh, wr, s, ci, cv, iv, ix, bz, dn};
  endfunction

  localparam logic [12:0] IDLE_V = 13'b1_0_0_00_0_0_0_000_0_0;
  localparam logic [12:0] DONE_V = 13'b0_0_0_00_0_0_0_000_1_1;

  // Inputs are applied 1ns after a rising edge; check mid-cycle, then
  // advance to just after the next rising edge.
  task automatic cyc(input string tag, input logic [12:0] exp);
    #4;
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; valid = 1'b1; op = ADD; stall = 1'b1;
    @(posedge clk); #1;
    cyc("reset_a", IDLE_V);
    cyc("reset_b", IDLE_V);
    rst = 1'b0; valid = 1'b0; stall = 1'b1;
    cyc("idle_stall_ignored", IDLE_V);
    stall = 1'b0;

    // ADD, op input changed right after accept
    valid = 1'b1; op = ADD;
    cyc("add_accept", v(1,0,0,2'd0,1,0,0,3'd0,0,0));
    valid = 1'b0; op = SUB;
    for (int i = 0; i < 8; i++) cyc("add_shift", v(0,1,1,2'd1,0,0,0,3'(i),1,0));
    cyc("add_done", DONE_V);
    cyc("add_idle", IDLE_V);

    // SUB
    valid = 1'b1; op = SUB;
    cyc("sub_accept", v(1,0,0,2'd0,1,1,0,3'd0,0,0));
    valid = 1'b0; op = NOP;
    for (int i = 0; i < 8; i++) cyc("sub_shift", v(0,1,1,2'd1,0,0,1,3'(i),1,0));
    cyc("sub_done", DONE_V);
    cyc("sub_idle", IDLE_V);

    // LOAD with a two-cycle stall on bit 3
    valid = 1'b1; op = LOAD;
    cyc("load_accept", v(1,0,0,2'd0,1,0,0,3'd0,0,0));
    valid = 1'b0;
    for (int i = 0; i < 3; i++) cyc("load_shift", v(0,1,1,2'd0,0,0,0,3'(i),1,0));
    stall = 1'b1;
    cyc("load_stall1", v(0,0,0,2'd0,0,0,0,3'd3,1,0));
    cyc("load_stall2", v(0,0,0,2'd0,0,0,0,3'd3,1,0));
    stall = 1'b0;
    for (int i = 3; i < 8; i++) cyc("load_shift", v(0,1,1,2'd0,0,0,0,3'(i),1,0));
    cyc("load_done", DONE_V);
    cyc("load_idle", IDLE_V);

    // ROT aborted by reset during bit 5
    valid = 1'b1; op = ROT;
    cyc("rot_accept", v(1,0,0,2'd0,1,0,0,3'd0,0,0));
    valid = 1'b0;
    for (int i = 0; i < 5; i++) cyc("rot_shift", v(0,1,1,2'd2,0,0,0,3'(i),1,0));
    rst = 1'b1;
    cyc("rot_reset", IDLE_V);
    rst = 1'b0;
    cyc("rot_after_reset", IDLE_V);
    cyc("rot_no_done", IDLE_V);

    // CLR after the abort
    valid = 1'b1; op = CLR;
    cyc("clr_accept", v(1,0,0,2'd0,1,0,0,3'd0,0,0));
    valid = 1'b0;
    for (int i = 0; i < 8; i++) cyc("clr_shift", v(0,1,0,2'd0,0,0,0,3'(i),1,0));
    cyc("clr_done", DONE_V);
    cyc("clr_idle", IDLE_V);

    // Reserved op 7
    valid = 1'b1; op = op_e'(3'd7);
    cyc("rsv_accept", IDLE_V);
    valid = 1'b0;
    cyc("rsv_done", DONE_V);
    cyc("rsv_idle", IDLE_V);

    // i_valid held high: accepts every 10 cycles, never while busy
    valid = 1'b1; op = ADD;
    for (int k = 0; k < 2; k++) begin
      cyc("b2b_accept", v(1,0,0,2'd0,1,0,0,3'd0,0,0));
      for (int i = 0; i < 8; i++) cyc("b2b_shift", v(0,1,1,2'd1,0,0,0,3'(i),1,0));
      cyc("b2b_done", DONE_V);
    end
    cyc("b2b_third_accept", v(1,0,0,2'd0,1,0,0,3'd0,0,0));
    valid = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
